// File: rtl/spi_slave_pkg.sv
// Shared SPI slave definitions: default receive-path sizing and command opcodes.
package spi_slave_pkg;

    localparam int SPI_DATA_WIDTH   = 32;
    localparam int SPI_RX_DEPTH     = 8;
    localparam int SPI_AFULL_MARGIN = 2;

    typedef enum logic [7:0] {
        SPI_CMD_NOP    = 8'h00,
        SPI_CMD_WRITE  = 8'h02,
        SPI_CMD_READ   = 8'h03,
        SPI_CMD_STATUS = 8'h05
    } spi_cmd_e;

    // Even parity over a command byte, used by the command decoder.
    function automatic logic spi_cmd_parity(input logic [7:0] cmd);
        return ^cmd;
    endfunction

endpackage

// File: rtl/spi_slave_rx_syncfifo_if.sv
// Receive FIFO handshake bundle: SPI receive side in, AXI master plug side out.
interface spi_slave_rx_syncfifo_if
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH   = SPI_DATA_WIDTH,
    parameter int BUFFER_DEPTH = SPI_RX_DEPTH
);
    localparam int CNT_W = $clog2(BUFFER_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_in;
    logic [CNT_W-1:0]      elements;
    logic                  almost_full;

    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, data_out, valid_out, elements, almost_full
    );

    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out, elements, almost_full
    );

endinterface

// File: rtl/spi_slave_rx_syncfifo.sv
// Single-clock receive FIFO between the SPI shift logic and the AXI master plug.
// Occupancy counter is the only control state; flush clears it synchronously.
module spi_slave_rx_syncfifo
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH   = SPI_DATA_WIDTH,
    parameter int BUFFER_DEPTH = SPI_RX_DEPTH,
    parameter int AFULL_MARGIN = SPI_AFULL_MARGIN
)(
    input  logic axi_aclk,
    input  logic axi_aresetn,
    input  logic flush,
    spi_slave_rx_syncfifo_if.slave fifo_if
);

    localparam int PTR_W     = $clog2(BUFFER_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int AFULL_THR = BUFFER_DEPTH - AFULL_MARGIN;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_elements;

    logic w_ready_out;
    logic w_valid_out;
    logic w_push;
    logic w_pop;

    // Handshake decode from the registered occupancy only.
    always_comb begin
        w_ready_out = (r_elements != CNT_FULL);
        w_valid_out = (r_elements != CNT_ZERO);
        w_push      = fifo_if.valid_in & w_ready_out;
        w_pop       = w_valid_out & fifo_if.ready_in;
    end

    // Storage array, intentionally without reset.
    always_ff @(posedge axi_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fifo_if.data_in;
        end
    end

    // Pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_elements <= CNT_ZERO;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_elements <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_elements <= r_elements + CNT_ONE;
                2'b01:   r_elements <= r_elements - CNT_ONE;
                default: r_elements <= r_elements;
            endcase
        end
    end

    assign fifo_if.ready_out   = w_ready_out;
    assign fifo_if.valid_out   = w_valid_out;
    assign fifo_if.data_out    = r_mem[r_rd_ptr];
    assign fifo_if.elements    = r_elements;
    assign fifo_if.almost_full = (int'(r_elements) >= AFULL_THR);

endmodule

// File: tb/tb_spi_slave_rx_syncfifo.sv
// Directed and randomized checks of the receive FIFO against a queue reference.
module tb_spi_slave_rx_syncfifo;

    localparam int DW     = 32;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic axi_aclk;
    logic axi_aresetn;
    logic flush;

    spi_slave_rx_syncfifo_if #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) rx_if ();

    spi_slave_rx_syncfifo #(
        .DATA_WIDTH  (DW),
        .BUFFER_DEPTH(DEPTH),
        .AFULL_MARGIN(MARGIN)
    ) dut (
        .axi_aclk   (axi_aclk),
        .axi_aresetn(axi_aresetn),
        .flush      (flush),
        .fifo_if    (rx_if)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    int n_checks = 0;
    int n_fails  = 0;
    logic [DW-1:0] q[$];

    task automatic check_state(input string tag);
        n_checks++;
        assert (rx_if.valid_out === (q.size() != 0)) else begin
            n_fails++;
            $error("FAIL %s valid_out got %b exp %b", tag, rx_if.valid_out, (q.size() != 0));
        end
        n_checks++;
        assert (rx_if.ready_out === (q.size() != DEPTH)) else begin
            n_fails++;
            $error("FAIL %s ready_out got %b exp %b", tag, rx_if.ready_out, (q.size() != DEPTH));
        end
        n_checks++;
        assert (rx_if.elements === 4'(q.size())) else begin
            n_fails++;
            $error("FAIL %s elements got %0d exp %0d", tag, rx_if.elements, q.size());
        end
        n_checks++;
        assert (rx_if.almost_full === (q.size() >= DEPTH - MARGIN)) else begin
            n_fails++;
            $error("FAIL %s almost_full got %b exp %b", tag, rx_if.almost_full, (q.size() >= DEPTH - MARGIN));
        end
        if (q.size() != 0) begin
            n_checks++;
            assert (rx_if.data_out === q[0]) else begin
                n_fails++;
                $error("FAIL %s data_out got %h exp %h", tag, rx_if.data_out, q[0]);
            end
        end
    endtask

    // One clock: drive inputs, apply FIFO rules to the reference, then check.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic f, input string tag);
        bit do_push;
        bit do_pop;
        rx_if.valid_in = v;
        rx_if.data_in  = d;
        rx_if.ready_in = r;
        flush          = f;
        do_push = v && (q.size() < DEPTH);
        do_pop  = r && (q.size() > 0);
        @(posedge axi_aclk);
        if (f) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        axi_aresetn    = 1'b0;
        flush          = 1'b0;
        rx_if.valid_in = 1'b0;
        rx_if.data_in  = '0;
        rx_if.ready_in = 1'b0;
        repeat (2) @(posedge axi_aclk);
        #1;
        check_state("reset");
        axi_aresetn = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, "idle");

        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, "first_push");
        n_checks++;
        assert (rx_if.data_out === 32'hA5A5_0001) else begin
            n_fails++;
            $error("FAIL first_word got %h exp %h", rx_if.data_out, 32'hA5A5_0001);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, "drain_one");
        step(1'b0, 32'h0, 1'b1, 1'b0, "pop_empty");

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b0, "fill");
        end
        n_checks++;
        assert (rx_if.elements === 4'd8 && rx_if.ready_out === 1'b0) else begin
            n_fails++;
            $error("FAIL full elements=%0d ready_out=%b exp 8/0", rx_if.elements, rx_if.ready_out);
        end
        step(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, "push_when_full");
        step(1'b1, 32'h1234_5678, 1'b1, 1'b0, "full_pop_push");
        n_checks++;
        assert (rx_if.elements === 4'd7) else begin
            n_fails++;
            $error("FAIL full_pop elements got %0d exp 7", rx_if.elements);
        end
        while (q.size() != 0) step(1'b0, 32'h0, 1'b1, 1'b0, "drain");

        step(1'b1, 32'h0, 1'b0, 1'b0, "stream_start");
        for (int i = 1; i < 20; i++) begin
            n_checks++;
            assert (rx_if.data_out === 32'(i - 1)) else begin
                n_fails++;
                $error("FAIL stream_order got %h exp %h", rx_if.data_out, 32'(i - 1));
            end
            step(1'b1, 32'(i), 1'b1, 1'b0, "stream");
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, "stream_end");

        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, "pre_flush");
        step(1'b1, 32'h5555_AAAA, 1'b1, 1'b1, "flush");
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "post_flush_push");
        n_checks++;
        assert (rx_if.data_out === 32'hDEAD_BEEF) else begin
            n_fails++;
            $error("FAIL post_flush_word got %h exp %h", rx_if.data_out, 32'hDEAD_BEEF);
        end

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(3, 0) != 0), $urandom, $urandom_range(1, 0) == 1,
                 ($urandom_range(31, 0) == 0), "random");
        end

        while (q.size() != 0) step(1'b0, 32'h0, 1'b1, 1'b0, "drain2");
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, "burst");
        #3;
        axi_aresetn = 1'b0;
        q.delete();
        #1;
        check_state("async_reset");
        @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
        step(1'b1, 32'hC0FF_EE01, 1'b0, 1'b0, "after_reset_push");
        step(1'b1, 32'hC0FF_EE02, 1'b0, 1'b0, "after_reset_push2");
        n_checks++;
        assert (rx_if.data_out === 32'hC0FF_EE01) else begin
            n_fails++;
            $error("FAIL after_reset_first got %h exp %h", rx_if.data_out, 32'hC0FF_EE01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx_syncfifo.md
SPI_SLAVE_RX_SYNCFIFO -- requirements
Module: spi_slave_rx_syncfifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each stored word.
REQ-002 Parameter BUFFER_DEPTH, default 8, number of entries; SHALL be a power of two and at least 2.
REQ-003 Parameter AFULL_MARGIN, default 2, free-entry margin at which almost_full asserts.
REQ-004 axi_aclk  input  1  single clock; all state updates on its rising edge.
REQ-005 axi_aresetn  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous clear of all stored entries, driven from SPI chip-select deassertion.
REQ-007 data_in  input  DATA_WIDTH  word from the SPI receive side.
REQ-008 valid_in  input  1  data_in holds a valid word.
REQ-009 ready_out  output  1  FIFO accepts a word this cycle.
REQ-010 data_out  output  DATA_WIDTH  oldest stored word, presented as rx_data to the AXI master plug.
REQ-011 valid_out  output  1  data_out is valid, presented as rx_valid.
REQ-012 ready_in  input  1  consumer takes data_out this cycle, driven from rx_ready.
REQ-013 elements  output  log2(BUFFER_DEPTH)+1  current occupancy, 0..BUFFER_DEPTH.
REQ-014 almost_full  output  1  elements >= BUFFER_DEPTH-AFULL_MARGIN.

Function
REQ-015 Push SHALL occur when valid_in and ready_out are both high.
REQ-016 Pop SHALL occur when valid_out and ready_in are both high.
REQ-017 ready_out SHALL equal (elements != BUFFER_DEPTH), decoded from registered state only, with no combinational path from ready_in.
REQ-018 valid_out SHALL equal (elements != 0), with no combinational path from valid_in.
REQ-019 data_out SHALL equal the storage entry at the read pointer, with no write-through bypass.
REQ-020 A word pushed in cycle N SHALL appear on valid_out/data_out in cycle N+1 at the earliest.
REQ-021 Write and read pointers SHALL be log2(BUFFER_DEPTH) bits wide and SHALL wrap modulo BUFFER_DEPTH without a gap.
REQ-022 Simultaneous push and pop SHALL leave elements unchanged and advance both pointers.
REQ-023 Push only SHALL increment elements by 1; pop only SHALL decrement it by 1.
REQ-024 When full, ready_out SHALL be low, and a pop in that cycle SHALL NOT enable a same-cycle push.
REQ-025 When empty, valid_out SHALL be low and ready_in SHALL be ignored.
REQ-026 flush SHALL zero both pointers and elements on the next edge, overriding any push or pop in the same cycle; storage contents need not be cleared.
REQ-027 Words SHALL be delivered in push order with no loss or duplication.
REQ-028 almost_full SHALL be a combinational decode of elements.

Reset
REQ-029 Asynchronous assertion of axi_aresetn SHALL clear the pointers and elements immediately.
REQ-030 While axi_aresetn is low, outputs SHALL be: ready_out=1, valid_out=0, elements=0, almost_full=0.
REQ-031 Storage RAM SHALL NOT be reset; data_out value is don't-care while valid_out=0.
REQ-032 Reset asserted mid-transfer SHALL discard all stored words; the first word pushed after deassertion SHALL be the first popped.

Structure
REQ-033 Default DATA_WIDTH/BUFFER_DEPTH constants SHALL live in shared package spi_slave_pkg, next to the SPI command opcodes; this block has no typedefs of its own.
REQ-034 The block SHALL have no sub-modules: a flat register-array storage plus two pointers and an occupancy counter.
REQ-035 The block SHALL have no state machine; elements is the sole control state.

Verification
REQ-036 Reset, push 0xA5A5_0001; valid_out=1 the next cycle with data_out=0xA5A5_0001 and elements=1.
REQ-037 Push 8 words with ready_in=0 -> ready_out=0 after the 8th, elements=8, almost_full asserted from elements=6, a 9th valid_in ignored.
REQ-038 Full FIFO, ready_in=1 and valid_in=1 in the same cycle -> one pop, no push, elements=7, and ready_out=1 the next cycle.
REQ-039 Continuous push/pop for 20 words 0x0..0x13 -> pointer wrap exercised, output order 0x0..0x13, elements constant at 1.
REQ-040 3 words stored, flush with simultaneous push and pop -> elements=0 and valid_out=0 next cycle; the next push of 0xDEAD_BEEF is the first popped.
REQ-041 Assert axi_aresetn low mid-burst with 5 words stored -> valid_out=0 and elements=0 immediately, without waiting for a clock edge.
